// File: rtl/skew_transpose_buffer_pkg.sv
// Shared constants, occupancy type and beat-count helper for the skew/transpose
// tile buffer.
package skew_buf_pkg;

  localparam int DEF_N    = 8;
  localparam int DEF_BITS = 8;
  localparam int DEF_SKEW = 1;

  // number of tiles resident in the two banks (0..2)
  typedef logic [1:0] occ_t;

  function automatic int num_beats(input int n, input int skew);
    return n + skew * (n - 1);
  endfunction

endpackage

// File: rtl/skew_transpose_buffer_if.sv
// Tile load port and beat stream port of the skew/transpose buffer.
interface skew_transpose_buffer_if
  import skew_buf_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int BITS = DEF_BITS
);

  logic                            ld_valid;
  logic                            ld_ready;
  logic                            ld_transpose;
  logic [N-1:0][N-1:0][BITS-1:0]   ld_tile;
  logic                            out_valid;
  logic                            out_ready;
  logic [N-1:0][BITS-1:0]          out_data;
  logic                            out_first;
  logic                            out_last;

  modport slave (
    input  ld_valid, ld_transpose, ld_tile, out_ready,
    output ld_ready, out_valid, out_data, out_first, out_last
  );

  modport master (
    output ld_valid, ld_transpose, ld_tile, out_ready,
    input  ld_ready, out_valid, out_data, out_first, out_last
  );

endinterface

// File: rtl/skew_transpose_buffer_tile_bank.sv
// One N x N tile bank with its transpose flag; each lane reads one element
// through a combinational row/column mux.
module tile_bank
  import skew_buf_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int BITS = DEF_BITS,
  parameter int IW   = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          ld_en,
  input  logic                          ld_transpose,
  input  logic [N-1:0][N-1:0][BITS-1:0] ld_tile,
  input  logic [N-1:0][IW-1:0]          elem_idx,
  output logic [N-1:0][BITS-1:0]        lane_data
);

  logic [N-1:0][N-1:0][BITS-1:0] tile;
  logic                          tr;

  // contents are don't-care after flush, so no reset on the storage
  always_ff @(posedge clk) begin
    if (ld_en) begin
      tile <= ld_tile;
      tr   <= ld_transpose;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_data[i] = tr ? tile[elem_idx[i]][i] : tile[i][elem_idx[i]];
  end

endmodule

// File: rtl/skew_transpose_buffer.sv
// Ping-pong N x N tile buffer: whole-tile load, optional transpose, streamed
// out one column-beat per cycle with optional per-lane diagonal skew.
module skew_transpose_buffer
  import skew_buf_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int BITS = DEF_BITS,
  parameter int SKEW = DEF_SKEW
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    clr,
  skew_transpose_buffer_if.slave bus
);

  localparam int B  = num_beats(N, SKEW);
  localparam int KW = $clog2(B);
  localparam int IW = $clog2(N);

  logic          wr_sel, rd_sel;
  occ_t          count;
  logic [KW-1:0] k;

  logic flush, accept, xfer, at_last, drain;
  logic [1:0]                   ld_en;
  logic [1:0][N-1:0][BITS-1:0]  bank_data;
  logic [N-1:0][IW-1:0]         elem_idx;
  logic [N-1:0]                 win;
  logic [N-1:0][BITS-1:0]       lane_out;

  assign flush   = rst | clr;
  assign bus.ld_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign accept  = bus.ld_valid & bus.ld_ready;
  assign xfer    = bus.out_valid & bus.out_ready;
  assign at_last = (k == KW'(B - 1));
  assign drain   = xfer & at_last;

  assign bus.out_first = bus.out_valid & (k == '0);
  assign bus.out_last  = bus.out_valid & at_last;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= '0;
      k      <= '0;
    end else begin
      if (accept) wr_sel <= ~wr_sel;
      if (xfer) begin
        if (at_last) begin
          k      <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          k <= k + 1'b1;
        end
      end
      // load and final-beat drain in the same cycle cancel out
      count <= count + occ_t'(accept) - occ_t'(drain);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign ld_en[b] = accept & ~flush & (wr_sel == 1'(b));

    tile_bank #(.N(N), .BITS(BITS), .IW(IW)) u_bank (
      .clk          (clk),
      .ld_en        (ld_en[b]),
      .ld_transpose (bus.ld_transpose),
      .ld_tile      (bus.ld_tile),
      .elem_idx     (elem_idx),
      .lane_data    (bank_data[b])
    );
  end

  // lane i sits SKEW*i beats behind lane 0; outside its N-beat window it is zero
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int OFF = SKEW * i;
    int rel;

    always_comb rel = int'(k) - OFF;

    assign win[i]      = (rel >= 0) && (rel < N);
    assign elem_idx[i] = win[i] ? IW'(N - 1 - rel) : '0;
    assign lane_out[i] = (bus.out_valid && win[i]) ? bank_data[rd_sel][i] : '0;
  end

  assign bus.out_data = lane_out;

endmodule

// File: tb/tb_skew_transpose_buffer.sv
// Two instances (SKEW=0 and SKEW=1) driven with the same stimulus and checked
// every cycle against a tile-queue reference model.
module tb_skew_transpose_buffer;
  import skew_buf_pkg::*;

  localparam int N    = 4;
  localparam int BITS = 8;

  typedef logic [N-1:0][N-1:0][BITS-1:0] tile_t;
  typedef logic [N-1:0][BITS-1:0]        beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic  ld_valid = 1'b0;
  logic  ld_tr    = 1'b0;
  logic  out_ready = 1'b0;
  tile_t ld_tile  = '0;

  skew_transpose_buffer_if #(.N(N), .BITS(BITS)) bus0 ();
  skew_transpose_buffer_if #(.N(N), .BITS(BITS)) bus1 ();

  assign bus0.ld_valid = ld_valid;
  assign bus0.ld_transpose = ld_tr;
  assign bus0.ld_tile = ld_tile;
  assign bus0.out_ready = out_ready;
  assign bus1.ld_valid = ld_valid;
  assign bus1.ld_transpose = ld_tr;
  assign bus1.ld_tile = ld_tile;
  assign bus1.out_ready = out_ready;

  skew_transpose_buffer #(.N(N), .BITS(BITS), .SKEW(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus0));
  skew_transpose_buffer #(.N(N), .BITS(BITS), .SKEW(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus1));

  // reference model: per instance, a 2-deep FIFO of tiles plus beat index
  tile_t mt [2][2];
  bit    mtr[2][2];
  int    mhead[2] = '{0, 0};
  int    mcnt [2] = '{0, 0};
  int    mk   [2] = '{0, 0};

  int errors = 0, checks = 0, cyc = 0;
  beat_t log0[$], log1[$];
  int    acc1[$], last1[$];
  int    run1 = 0, maxrun1 = 0;

  function automatic int nb(int skew);
    return N + skew * (N - 1);
  endfunction

  function automatic beat_t ref_beat(tile_t t, bit tr, int k, int skew);
    beat_t b = '0;
    for (int i = 0; i < N; i++) begin
      int j = k - skew * i;
      if (j >= 0 && j < N) b[i] = tr ? t[N-1-j][i] : t[i][N-1-j];
    end
    return b;
  endfunction

  function automatic tile_t ramp();
    tile_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) t[r][c] = BITS'(16 * r + c);
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) t[r][c] = BITS'($urandom);
    return t;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(int d);
    bit acc, xf, fin;
    int tail;
    acc = ld_valid && (mcnt[d] < 2);
    xf  = (mcnt[d] > 0) && out_ready;
    fin = xf && (mk[d] == nb(d) - 1);
    if (rst || clr) begin
      mcnt[d] = 0; mhead[d] = 0; mk[d] = 0;
    end else begin
      if (d == 1 && acc) acc1.push_back(cyc);
      if (d == 1 && fin) last1.push_back(cyc);
      tail = (mhead[d] + mcnt[d]) % 2;
      if (xf) begin
        if (fin) begin
          mk[d] = 0; mhead[d] = 1 - mhead[d]; mcnt[d]--;
        end else mk[d]++;
      end
      if (acc) begin
        mt[d][tail] = ld_tile; mtr[d][tail] = ld_tr; mcnt[d]++;
      end
    end
  endtask

  task automatic tick();
    beat_t od, eb;
    logic  ordy, ov, ofst, olst;
    bit    ev;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        od = bus0.out_data; ordy = bus0.ld_ready; ov = bus0.out_valid;
        ofst = bus0.out_first; olst = bus0.out_last;
      end else begin
        od = bus1.out_data; ordy = bus1.ld_ready; ov = bus1.out_valid;
        ofst = bus1.out_first; olst = bus1.out_last;
      end
      ev = mcnt[d] > 0;
      eb = ev ? ref_beat(mt[d][mhead[d]], mtr[d][mhead[d]], mk[d], d) : '0;
      chk($sformatf("s%0d_ld_ready@%0d", d, cyc), 64'(ordy), 64'(mcnt[d] < 2));
      chk($sformatf("s%0d_out_valid@%0d", d, cyc), 64'(ov), 64'(ev));
      chk($sformatf("s%0d_out_first@%0d", d, cyc), 64'(ofst), 64'(ev && mk[d] == 0));
      chk($sformatf("s%0d_out_last@%0d", d, cyc), 64'(olst), 64'(ev && mk[d] == nb(d) - 1));
      chk($sformatf("s%0d_out_data@%0d", d, cyc), 64'(od), 64'(eb));
      if (ov === 1'b1 && out_ready) begin
        if (d == 0) log0.push_back(od); else log1.push_back(od);
      end
    end
    if (bus1.out_valid === 1'b1) run1++; else run1 = 0;
    if (run1 > maxrun1) maxrun1 = run1;
    model_update(0);
    model_update(1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ld_valid = 1'b0; out_ready = 1'b1; clr = 1'b0; rst = 1'b0;
    repeat (20) tick();
  endtask

  task automatic wait_beat(int kk);
    int g = 0;
    while (!(mcnt[1] > 0 && mk[1] == kk) && g < 30) begin
      tick(); g++;
    end
    chk($sformatf("wait_beat%0d_timeout", kk), 64'(g < 30), 64'(1));
  endtask

  initial begin
    tile_t t;
    rst = 1'b1;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    chk("reset_ld_ready", 64'(bus1.ld_ready), 64'(1));
    chk("reset_out_valid", 64'(bus1.out_valid), 64'(0));
    chk("reset_out_data", 64'(bus1.out_data), 64'(0));

    // ramp tile, row mode
    log0.delete(); log1.delete();
    ld_tile = ramp(); ld_tr = 1'b0; ld_valid = 1'b1; out_ready = 1'b1;
    tick();
    ld_valid = 1'b0;
    repeat (10) tick();
    chk("rowmode_s1_beats", 64'(log1.size()), 64'(7));
    chk("rowmode_s0_beats", 64'(log0.size()), 64'(4));
    if (log1.size() == 7) begin
      chk("rowmode_s1_beat0", 64'(log1[0]), 64'h0000_0003);
      chk("rowmode_s1_beat3", 64'(log1[3]), 64'h3322_1100);
      chk("rowmode_s1_beat6", 64'(log1[6]), 64'h3000_0000);
    end

    // ramp tile, transpose mode
    log0.delete(); log1.delete();
    ld_tr = 1'b1; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    repeat (10) tick();
    chk("trmode_s0_beats", 64'(log0.size()), 64'(4));
    if (log0.size() == 4) begin
      chk("trmode_s0_beat0", 64'(log0[0]), 64'h3332_3130);
      chk("trmode_s0_beat3", 64'(log0[3]), 64'h0302_0100);
    end

    // three tiles back-to-back
    drain();
    acc1.delete(); last1.delete(); maxrun1 = 0;
    ld_tr = 1'(($urandom));
    ld_valid = 1'b1;
    for (int g = 0; g < 40 && acc1.size() < 3; g++) begin
      ld_tile = rand_tile();
      tick();
    end
    ld_valid = 1'b0;
    repeat (25) tick();
    chk("b2b_contiguous_beats", 64'(maxrun1), 64'(21));
    chk("b2b_accepts", 64'(acc1.size()), 64'(3));
    if (acc1.size() == 3 && last1.size() >= 1) begin
      chk("b2b_second_accept", 64'(acc1[1]), 64'(acc1[0] + 1));
      chk("b2b_third_after_last", 64'(acc1[2]), 64'(last1[0] + 1));
    end

    // stall on beat 2
    drain();
    log1.delete();
    t = rand_tile();
    ld_tile = t; ld_tr = 1'b0; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    repeat (10) tick();
    chk("stall_beats", 64'(log1.size()), 64'(7));
    for (int b = 0; b < 7 && b < log1.size(); b++)
      chk($sformatf("stall_beat%0d", b), 64'(log1[b]), 64'(ref_beat(t, 1'b0, b, 1)));

    // accept coinciding with final-beat transfer
    drain();
    ld_tile = ramp(); ld_tr = 1'b0; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    wait_beat(6);
    ld_tile = rand_tile(); ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("overlap_out_first", 64'(bus1.out_first), 64'(1));
    chk("overlap_ld_ready", 64'(bus1.ld_ready), 64'(1));
    repeat (8) tick();

    // clr, then rst, at beat 3 with a simultaneous load
    for (int p = 0; p < 2; p++) begin
      drain();
      ld_tile = rand_tile(); ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      wait_beat(3);
      if (p == 0) clr = 1'b1; else rst = 1'b1;
      ld_tile = rand_tile(); ld_valid = 1'b1;
      tick();
      clr = 1'b0; rst = 1'b0; ld_valid = 1'b0;
      chk($sformatf("flush%0d_out_valid", p), 64'(bus1.out_valid), 64'(0));
      chk($sformatf("flush%0d_ld_ready", p), 64'(bus1.ld_ready), 64'(1));
      chk($sformatf("flush%0d_out_data", p), 64'(bus1.out_data), 64'(0));
      repeat (3) tick();
      chk($sformatf("flush%0d_discarded", p), 64'(bus1.out_valid), 64'(0));
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ld_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      ld_tr     = 1'($urandom_range(0, 1));
      ld_tile   = rand_tile();
      tick();
    end
    clr = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
